// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: receives 8N1 command frames ('W' addr data / 'R' addr) and runs single
// write/read cycles on the 8-bit I/O bus. It answers with an ACK byte, the read data or a NAK.
module uart_bus_bridge #(
  parameter logic [7:0] BAUD_DIV = 8'd0,
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter logic [7:0] NAK_BYTE = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] address,
  output logic [7:0] dout,
  output logic       w_en,
  output logic       r_en,
  input  logic [7:0] din,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxArm, TxRun} tx_state_e;
  typedef enum logic [2:0] {
    StCmd, StAddrW, StDataW, StBusWr, StAddrR, StBusRd, StCapture, StSend
  } cmd_state_e;

  logic [7:0] presc_q;
  logic       tick;
  logic       rx_meta_q, rx_sync_q;

  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;

  tx_state_e  tx_state_q, tx_state_d;
  logic [8:0] tx_shift_q, tx_shift_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic       tx_q, tx_d;
  logic       tx_done, tx_start;
  logic [7:0] tx_data;

  cmd_state_e cmd_q, cmd_d;
  logic [7:0] address_q, dout_q;
  logic       addr_load, dout_load;

  assign tick = (presc_q == BAUD_DIV);

  // Free-running sample-tick prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= tick ? 8'd0 : presc_q + 8'd1;
  end

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Receiver next state: mid-bit sampling, 16 ticks per bit, LSB first.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (tick && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (tick) begin
          if (rx_cnt_q == 4'd7) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            // A high line at mid start bit is a glitch, not a frame.
            rx_state_d = rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
      end
      RxData: begin
        if (tick) begin
          if (rx_cnt_q == 4'd15) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
      end
      RxStop: begin
        if (tick) begin
          if (rx_cnt_q == 4'd15) begin
            rx_cnt_d = '0;
            if (rx_sync_q) begin
              rx_valid_d = 1'b1;
              rx_state_d = RxIdle;
            end else begin
              frame_err_d = 1'b1;
              rx_state_d  = RxWait;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
      end
      RxWait: begin
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Transmitter state and shift registers; tx idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_done = (tx_state_q == TxRun) && tick && (tx_cnt_q == 4'd15) && (tx_bit_q == 4'd9);

  // Transmitter next state: start bit at the next tick, then data LSB first and stop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TxIdle: begin
        if (tx_start) begin
          tx_shift_d = {1'b1, tx_data};
          tx_state_d = TxArm;
        end
      end
      TxArm: begin
        if (tick) begin
          tx_d       = 1'b0;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxRun;
        end
      end
      TxRun: begin
        if (tick) begin
          if (tx_cnt_q == 4'd15) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
              tx_d       = 1'b1;
              tx_state_d = TxIdle;
            end else begin
              tx_d       = tx_shift_q[0];
              tx_shift_d = {1'b1, tx_shift_q[8:1]};
              tx_bit_d   = tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // Command FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cmd_q <= StCmd;
    else      cmd_q <= cmd_d;
  end

  // Command FSM next state; a framing error drops a partially received command.
  always_comb begin
    cmd_d = cmd_q;
    case (cmd_q)
      StCmd: begin
        if (rx_valid_q) begin
          if (rx_shift_q == CmdWrite)     cmd_d = StAddrW;
          else if (rx_shift_q == CmdRead) cmd_d = StAddrR;
          else                            cmd_d = StSend;
        end
      end
      StAddrW: begin
        if (frame_err_q)     cmd_d = StCmd;
        else if (rx_valid_q) cmd_d = StDataW;
      end
      StDataW: begin
        if (frame_err_q)     cmd_d = StCmd;
        else if (rx_valid_q) cmd_d = StBusWr;
      end
      StBusWr: cmd_d = StSend;
      StAddrR: begin
        if (frame_err_q)     cmd_d = StCmd;
        else if (rx_valid_q) cmd_d = StBusRd;
      end
      StBusRd:   cmd_d = StCapture;
      StCapture: cmd_d = StSend;
      StSend: begin
        if (tx_done) cmd_d = StCmd;
      end
      default: cmd_d = StCmd;
    endcase
  end

  // Command FSM outputs: bus strobes, register loads, response request and status.
  always_comb begin
    w_en      = (cmd_q == StBusWr);
    r_en      = (cmd_q == StBusRd);
    addr_load = rx_valid_q && ((cmd_q == StAddrW) || (cmd_q == StAddrR));
    dout_load = rx_valid_q && (cmd_q == StDataW);
    tx_start  = 1'b0;
    tx_data   = NAK_BYTE;
    if (cmd_q == StCmd && rx_valid_q && rx_shift_q != CmdWrite && rx_shift_q != CmdRead) begin
      tx_start = 1'b1;
    end else if (cmd_q == StBusWr) begin
      tx_start = 1'b1;
      tx_data  = ACK_BYTE;
    end else if (cmd_q == StCapture) begin
      tx_start = 1'b1;
      tx_data  = din;
    end
    // Busy covers the first byte's arrival cycle and drops as the stop bit completes.
    if (cmd_q == StCmd) busy = rx_valid_q;
    else                busy = !((cmd_q == StSend) && tx_done);
    overrun = rx_valid_q && ((cmd_q == StBusWr) || (cmd_q == StBusRd) ||
                             (cmd_q == StCapture) || (cmd_q == StSend));
  end

  // Bus address and write data hold their last values between cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      address_q <= '0;
      dout_q    <= '0;
    end else begin
      if (addr_load) address_q <= rx_shift_q;
      if (dout_load) dout_q    <= rx_shift_q;
    end
  end

  assign address   = address_q;
  assign dout      = dout_q;
  assign tx        = tx_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: serial command driver, bus peripheral model,
// serial response decoder and a memory-level reference model.
module tb_uart_bus_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tx;
  logic [7:0] address, dout, din;
  logic       w_en, r_en, busy, frame_err, overrun;

  int checks = 0;
  int errors = 0;

  int w_cnt = 0, r_cnt = 0, both_cnt = 0, fe_cnt = 0, ov_cnt = 0, busy_cnt = 0;
  logic [7:0] w_addr = 8'h00, w_data = 8'h00, r_addr = 8'h00;

  // Bus peripheral: unwritten location a reads as a*5.
  logic [7:0] bus_mem [256];
  bit         written [256];
  logic [7:0] rd_addr_q = 8'h00;
  int         rd_pend = 0;

  // Reference model of the peripheral's contents, driven by the commands the bench issues.
  logic [7:0] ref_mem [256];

  logic [8:0] rxq [$];

  always #5 clk = ~clk;

  uart_bus_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tx        (tx),
    .address   (address),
    .dout      (dout),
    .w_en      (w_en),
    .r_en      (r_en),
    .din       (din),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  function automatic logic [7:0] mem_rd(input logic [7:0] a);
    return written[a] ? bus_mem[a] : 8'(a * 8'd5);
  endfunction

  // Bus monitor and peripheral; read data is valid only in the cycle after r_en.
  always @(negedge clk) begin
    if (w_en) begin
      w_cnt++;
      w_addr = address;
      w_data = dout;
      bus_mem[address] = dout;
      written[address] = 1'b1;
    end
    if (rd_pend == 1) begin
      din = mem_rd(rd_addr_q);
      rd_pend = 0;
    end else begin
      din = ~mem_rd(rd_addr_q);
    end
    if (r_en) begin
      r_cnt++;
      r_addr = address;
      rd_addr_q = address;
      rd_pend = 1;
    end
    if (w_en && r_en) both_cnt++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) busy_cnt++;
  end

  // Serial response decoder: pushes {stop_bit, data}.
  initial begin : tx_decoder
    logic [7:0] b;
    logic       sb;
    forever begin
      @(negedge tx);
      repeat (8) @(negedge clk);
      if (tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx;
        end
        repeat (16) @(negedge clk);
        sb = tx;
        rxq.push_back({sb, b});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = good_stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_resp(output logic [8:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    for (int i = 0; i < 600; i++) begin
      if (rxq.size() > 0) begin
        v  = rxq.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // kind 0 = write, 1 = read, 2 = unknown opcode
  task automatic txn(input int kind, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] op);
    logic [8:0] got;
    bit         ok;
    int         w0, r0;
    logic [7:0] exp;
    w0 = w_cnt;
    r0 = r_cnt;
    if (kind == 0) begin
      send_byte(8'h57, 1'b1);
      send_byte(a, 1'b1);
      send_byte(d, 1'b1);
      ref_mem[a] = d;
      exp = 8'h4B;
    end else if (kind == 1) begin
      send_byte(8'h52, 1'b1);
      send_byte(a, 1'b1);
      exp = ref_mem[a];
    end else begin
      send_byte(op, 1'b1);
      exp = 8'h3F;
    end
    wait_resp(got, ok);
    chk("resp_seen", 32'(ok), 32'd1);
    chk("resp_byte", 32'(got[7:0]), 32'(exp));
    chk("resp_stop", 32'(got[8]), 32'd1);
    chk("busy_in_resp", 32'(busy), 32'd1);
    repeat (24) @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("tx_idle", 32'(tx), 32'd1);
    chk("w_count", 32'(w_cnt - w0), 32'(kind == 0));
    chk("r_count", 32'(r_cnt - r0), 32'(kind == 1));
    if (kind == 0) begin
      chk("w_addr", 32'(w_addr), 32'(a));
      chk("w_data", 32'(w_data), 32'(d));
    end
    if (kind == 1) chk("r_addr", 32'(r_addr), 32'(a));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx"}, 32'(tx), 32'd1);
    chk({tag, "_w_en"}, 32'(w_en), 32'd0);
    chk({tag, "_r_en"}, 32'(r_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_address"}, 32'(address), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
  endtask

  initial begin : main
    int         fe0, w0, r0, b0, kind;
    logic [7:0] a, d, op;
    bit         found;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 5);
    rst = 1'b1;
    rx  = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Directed: write, read, unknown opcode.
    txn(0, 8'h10, 8'hA5, 8'h00);
    txn(1, 8'h12, 8'h00, 8'h00);
    txn(2, 8'h00, 8'h00, 8'h7E);

    // Framing error on the address byte aborts the write silently.
    fe0 = fe_cnt;
    w0  = w_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b0);
    repeat (300) @(negedge clk);
    chk("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    chk("fe_no_write", 32'(w_cnt - w0), 32'd0);
    chk("fe_no_resp", 32'(rxq.size()), 32'd0);
    chk("fe_busy_low", 32'(busy), 32'd0);
    txn(1, 8'h00, 8'h00, 8'h00);

    // Short low glitch on idle line.
    fe0 = fe_cnt;
    w0  = w_cnt;
    r0  = r_cnt;
    b0  = busy_cnt;
    rx  = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("glitch_no_busy", 32'(busy_cnt - b0), 32'd0);
    chk("glitch_no_resp", 32'(rxq.size()), 32'd0);
    chk("glitch_no_bus", 32'((w_cnt - w0) + (r_cnt - r0)), 32'd0);

    // Random mix of commands checked against the reference memory.
    for (int n = 0; n < 12; n++) begin
      kind = int'($urandom_range(2, 0));
      a    = 8'($urandom_range(255, 1));
      d    = 8'($urandom);
      do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
      txn(kind, a, d, op);
    end

    // Reset in the 4th data bit of a response whose data bits are all 0.
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_resp_started", 32'(found), 32'd1);
    repeat (64 + 8) @(negedge clk);
    chk("rst_pre_tx_low", 32'(tx), 32'd0);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    rxq.delete();
    txn(0, 8'h01, 8'h02, 8'h00);

    chk("never_both_strobes", 32'(both_cnt), 32'd0);
    chk("no_overrun", 32'(ov_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
